match_scorekeeper: RTL

- Drives the finish detector. Receives one round outcome per handshake and keeps the registered round, win and lose tallies for a best-of-9 match.
- Presents the tallies to the combinational finish detector and reads back its fin and winner code.
- Stops accepting results once the match is decided, then holds the final score and winner until a new match starts.
- Sits between the round-judging logic (upstream) and the display logic (downstream).

---
 rtl/match_scorekeeper_pkg.sv | 14 +
 rtl/match_scorekeeper_if.sv | 10 +
 rtl/match_scorekeeper_tally_counter.sv | 25 ++
 rtl/match_scorekeeper.sv | 78 +++++++
 4 files changed

// File: rtl/match_scorekeeper_pkg.sv
// Shared types and codes for the match scorekeeper: FSM states, round result
// codes and the winner codes returned by the finish detector.
package match_scorekeeper_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_CHECK, ST_DONE} state_e;

  localparam logic [1:0] RES_BAD  = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  localparam logic [1:0] WIN_TIE  = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_P2   = 2'b11;
endpackage

// File: rtl/match_scorekeeper_if.sv
// Round-result handshake between the judging logic (master) and the
// scorekeeper (slave).
interface match_scorekeeper_if;
  logic       result_valid;
  logic [1:0] result;
  logic       result_ready;

  modport master (output result_valid, output result, input result_ready);
  modport slave  (input result_valid, input result, output result_ready);
endinterface

// File: rtl/match_scorekeeper_tally_counter.sv
// Saturation-free tally counter: synchronous clear wins over increment.
module tally_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/match_scorekeeper.sv
// Best-of-9 scorekeeper: accepts one round result per handshake, feeds the
// tallies to the external finish detector and latches its verdict.
module match_scorekeeper
  import match_scorekeeper_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int MAX_ROUNDS = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  match_scorekeeper_if.slave   res_if,
  output logic [CNT_W-1:0]     round_o,
  output logic [CNT_W-1:0]     win_o,
  output logic [CNT_W-1:0]     lose_o,
  input  logic                 fin_i,
  input  logic [1:0]           winner_i,
  output logic                 busy,
  output logic                 match_done,
  output logic [1:0]           winner_o,
  output logic                 err_pulse
);
  state_e     state_q, state_d;
  logic [1:0] winner_q;
  logic       done_q, err_q;
  logic       accept, legal, restart, finish;

  assign accept  = (state_q == ST_PLAY) && res_if.result_valid;
  assign legal   = res_if.result inside {RES_P1, RES_P2, RES_DRAW};
  assign restart = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Round cap backs up a detector that never raises fin.
  assign finish  = (state_q == ST_CHECK) &&
                   (fin_i || (round_o == CNT_W'(MAX_ROUNDS)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_PLAY;
      ST_PLAY:  if (accept && legal) state_d = ST_CHECK;
      ST_CHECK: state_d = finish ? ST_DONE : ST_PLAY;
      ST_DONE:  if (start) state_d = ST_PLAY;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      winner_q <= 2'b00;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == ST_DONE);
      err_q   <= accept && (res_if.result == RES_BAD);
      if (restart)     winner_q <= 2'b00;
      else if (finish) winner_q <= winner_i;
    end
  end

  tally_counter #(.CNT_W(CNT_W)) u_round (
    .clk(clk), .rst_n(rst_n), .clr_i(restart),
    .inc_i(accept && legal), .cnt_o(round_o));

  tally_counter #(.CNT_W(CNT_W)) u_win (
    .clk(clk), .rst_n(rst_n), .clr_i(restart),
    .inc_i(accept && (res_if.result == RES_P1)), .cnt_o(win_o));

  tally_counter #(.CNT_W(CNT_W)) u_lose (
    .clk(clk), .rst_n(rst_n), .clr_i(restart),
    .inc_i(accept && (res_if.result == RES_P2)), .cnt_o(lose_o));

  assign res_if.result_ready = (state_q == ST_PLAY);
  assign busy                = (state_q == ST_PLAY) || (state_q == ST_CHECK);
  assign match_done          = done_q;
  assign winner_o            = winner_q;
  assign err_pulse           = err_q;
endmodule
